// File: rtl/instr_loader.sv
// Writable instruction memory with a boot-load port.
// A host streams words over valid/ready into consecutive addresses starting at 0,
// while the core fetches combinationally through prog_ctr/mach_code.
module instr_loader #(
   parameter int D = 12,
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_req,
   input  logic [D:0]   load_len,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   input  logic [D-1:0] prog_ctr,
   output logic [W-1:0] mach_code,
   output logic         busy,
   output logic         core_hold,
   output logic         done,
   output logic         err,
   output logic [D:0]   word_cnt
);

   // Largest legal load length (a full memory) and a unit increment at counter width.
   localparam logic [D:0] DEPTH = {1'b1, {D{1'b0}}};
   localparam logic [D:0] ONE   = {{D{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DONE
   } state_t;

   state_t       state_reg, state_next;
   logic [D:0]   cnt_reg, cnt_next;   // doubles as the write pointer
   logic [D:0]   len_reg, len_next;
   logic         err_reg, err_next;

   logic [W-1:0] mem [2**D];

   logic         can_start;
   logic         len_zero;
   logic         len_ok;
   logic         beat;
   logic         last_beat;

   // A new request is only honoured outside LOAD; lengths above a full memory are refused,
   // which is what keeps the write pointer from ever wrapping.
   assign can_start = load_req && (state_reg != S_LOAD);
   assign len_zero  = (load_len == '0);
   assign len_ok    = (load_len <= DEPTH);
   assign beat      = (state_reg == S_LOAD) && in_valid;
   assign last_beat = beat && (cnt_reg == (len_reg - ONE));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE, S_DONE: begin
            if (can_start && len_ok) begin
               state_next = len_zero ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            if (last_beat) begin
               state_next = S_DONE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Output decode: everything except mach_code comes straight from registers
   always_comb begin
      in_ready  = (state_reg == S_LOAD);
      busy      = (state_reg == S_LOAD);
      core_hold = (state_reg == S_LOAD);
      done      = (state_reg == S_DONE);
      err       = err_reg;
      word_cnt  = cnt_reg;
   end

   // Datapath next values: count/length restart on an accepted request, count steps per beat
   always_comb begin
      cnt_next = cnt_reg;
      len_next = len_reg;
      err_next = err_reg;
      if (can_start) begin
         if (len_ok) begin
            cnt_next = '0;
            len_next = load_len;
            err_next = 1'b0;
         end else begin
            err_next = 1'b1;
         end
      end else if (beat) begin
         cnt_next = cnt_reg + ONE;
      end
   end

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
         len_reg <= '0;
         err_reg <= 1'b0;
      end else begin
         cnt_reg <= cnt_next;
         len_reg <= len_next;
         err_reg <= err_next;
      end
   end

   // Memory write; never reset, and beats cannot occur while reset holds the FSM in IDLE
   always_ff @(posedge clk) begin
      if (beat) begin
         mem[cnt_reg[D-1:0]] <= in_data;
      end
   end

   assign mach_code = mem[prog_ctr];

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: randomized data, scoreboard queues checked by
// an independent monitor, plus direct status and memory readback checks.
module tb_instr_loader;

   localparam int D     = 12;
   localparam int W     = 9;
   localparam int DEPTH = 1 << D;

   logic         clk = 1'b0;
   logic         reset;
   logic         load_req;
   logic [D:0]   load_len;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic [D-1:0] prog_ctr;
   logic [W-1:0] mach_code;
   logic         busy;
   logic         core_hold;
   logic         done;
   logic         err;
   logic [D:0]   word_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: memory image plus load bookkeeping
   logic [W-1:0] model_mem [DEPTH];
   bit           m_loading;
   bit           m_done;
   bit           m_err;
   int           m_cnt;
   int           m_len;

   // Scoreboard queues: expected word_cnt after each beat, expected word_cnt at done
   int beat_q[$];
   int done_q[$];

   bit mon_pending;
   bit mon_done_prev;

   instr_loader #(.D(D), .W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .load_req  (load_req),
      .load_len  (load_len),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .prog_ctr  (prog_ctr),
      .mach_code (mach_code),
      .busy      (busy),
      .core_hold (core_hold),
      .done      (done),
      .err       (err),
      .word_cnt  (word_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got event expected none at %0t", name, $time);
   endtask

   task automatic check_status(input string tag);
      check({tag, "_in_ready"},  in_ready,  m_loading);
      check({tag, "_busy"},      busy,      m_loading);
      check({tag, "_core_hold"}, core_hold, m_loading);
      check({tag, "_done"},      done,      m_done);
      check({tag, "_err"},       err,       m_err);
      check({tag, "_word_cnt"},  word_cnt,  m_cnt);
      $display("status %s: ready=%b done=%b err=%b cnt=%0d", tag, in_ready, done, err, word_cnt);
   endtask

   // Issue a load request; the model applies the acceptance rules directly
   task automatic request(input int len);
      load_req = 1'b1;
      load_len = len[D:0];
      if (!m_loading) begin
         if (len == 0) begin
            if (!m_done) done_q.push_back(0);
            m_done = 1; m_err = 0; m_cnt = 0;
         end else if (len <= DEPTH) begin
            m_loading = 1; m_done = 0; m_err = 0; m_cnt = 0; m_len = len;
         end else begin
            m_err = 1;
         end
      end
      @(posedge clk); #1;
      load_req = 1'b0;
      $display("request len=%0d", len);
   endtask

   // Offer n random words; gap inserts idle cycles; pulse_at fires a stray load_req
   task automatic stream(input int n, input bit gap, input int pulse_at);
      int sent = 0;
      int cyc  = 0;
      while (sent < n && cyc < 4 * n + 20) begin
         cyc++;
         in_valid = !(gap && (cyc % 2 == 0));
         in_data  = W'($urandom);
         load_req = (sent == pulse_at) && in_valid;
         load_len = 7;
         prog_ctr = D'(m_cnt);
         @(negedge clk);
         check("in_ready_cycle", in_ready, m_loading);
         if (!$isunknown(model_mem[m_cnt % DEPTH]))
            check("read_before_write", mach_code, model_mem[m_cnt % DEPTH]);
         if (in_valid && m_loading) begin
            model_mem[m_cnt] = in_data;
            m_cnt++;
            sent++;
            beat_q.push_back(m_cnt);
            if (m_cnt == m_len) begin
               m_loading = 0;
               m_done    = 1;
               done_q.push_back(m_len);
            end
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      load_req = 1'b0;
      if (sent < n) fail_now("stream_timeout");
   endtask

   task automatic readback(input int n);
      for (int i = 0; i < n; i++) begin
         prog_ctr = D'(i);
         #1;
         if (!$isunknown(model_mem[i])) check("readback", mach_code, model_mem[i]);
      end
      @(posedge clk); #1;
   endtask

   // Monitor: compares DUT-presented progress against scoreboard queues
   initial begin
      mon_pending   = 0;
      mon_done_prev = 0;
      forever begin
         @(negedge clk);
         if (reset) begin
            mon_pending   = 0;
            mon_done_prev = 0;
         end else begin
            if (mon_pending) begin
               if (beat_q.size() == 0) fail_now("beat_unexpected");
               else check("beat_word_cnt", word_cnt, beat_q.pop_front());
            end
            mon_pending = in_valid && in_ready;
            if (done && !mon_done_prev) begin
               if (done_q.size() == 0) fail_now("done_unexpected");
               else check("done_word_cnt", word_cnt, done_q.pop_front());
            end
            mon_done_prev = done;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int len;
      bit gap;
      reset = 1'b1; load_req = 0; load_len = '0; in_valid = 0; in_data = '0; prog_ctr = '0;
      m_loading = 0; m_done = 0; m_err = 0; m_cnt = 0; m_len = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check_status("reset");

      // Oversized request rejected, then a legal one clears err
      request(4097);
      check_status("reject");
      request(1);
      stream(1, 0, -1);
      check_status("after_reject_len1");

      // Three known words, in_valid held high
      request(3);
      in_valid = 1; in_data = 9'h07E; prog_ctr = '0;
      @(negedge clk); check("t1_ready0", in_ready, 1);
      model_mem[0] = 9'h07E; m_cnt = 1; beat_q.push_back(1);
      @(posedge clk); #1 in_data = 9'h066;
      @(negedge clk); check("t1_ready1", in_ready, 1);
      model_mem[1] = 9'h066; m_cnt = 2; beat_q.push_back(2);
      @(posedge clk); #1 in_data = 9'h07A;
      @(negedge clk); check("t1_ready2", in_ready, 1);
      model_mem[2] = 9'h07A; m_cnt = 3; beat_q.push_back(3);
      m_loading = 0; m_done = 1; done_q.push_back(3);
      @(posedge clk); #1 in_valid = 0;
      check_status("t1");
      readback(3);

      // Toggling valid
      request(4);
      stream(4, 1, -1);
      check_status("t2_toggle");
      readback(4);

      // Zero-length load
      request(0);
      check_status("t3_len0");
      readback(4);

      // Stray load_req mid-load, then reload from DONE
      request(4);
      stream(4, 0, 1);
      check_status("t6_stray_req");
      request(3);
      check_status("t6_reload_start");
      stream(3, 1, -1);
      check_status("t6_reload");
      readback(4);

      // Reset in the middle of a load
      request(5);
      stream(2, 0, -1);
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      m_loading = 0; m_done = 0; m_err = 0; m_cnt = 0;
      check_status("t5_async_reset");
      readback(2);
      reset = 1'b0;
      request(2);
      stream(2, 0, -1);
      check_status("t5_reload");
      readback(4);

      // Full-memory load
      request(DEPTH);
      stream(DEPTH, 0, -1);
      check_status("full_depth");
      readback(DEPTH);

      // Random short loads over the existing image
      for (int k = 0; k < 4; k++) begin
         len = $urandom_range(1, 24);
         gap = 1'($urandom_range(0, 1));
         request(len);
         stream(len, gap, -1);
         check_status("random");
         readback(32);
      end

      repeat (3) @(posedge clk);
      #1;
      check("beat_q_drained", beat_q.size(), 0);
      check("done_q_drained", done_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
